// File: rtl/puf_tx_serializer.sv
// puf_tx_serializer: shifts one PUF response frame (normal or debug length) out LSB-first
// over a valid/ready serial link and pulses o_frame_done after the final bit.
`default_nettype none

module puf_tx_serializer #(
  parameter int NORM_MOD  = 34,
  parameter int DEBUG_MOD = 133,
  parameter int CNT_W     = $clog2(DEBUG_MOD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_frame_valid,
  output logic                 o_frame_ready,
  input  logic                 i_frame_mode,
  input  logic [DEBUG_MOD-1:0] i_frame_data,
  input  logic                 i_flush,
  input  logic                 i_tx_ready,
  output logic                 o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Keeps only the low NORM_MOD payload bits of a normal-mode frame.
  localparam logic [DEBUG_MOD-1:0] NORM_MASK  = (DEBUG_MOD'(1) << NORM_MOD) - DEBUG_MOD'(1);
  localparam logic [CNT_W-1:0]     NORM_LEN   = CNT_W'(NORM_MOD);
  localparam logic [CNT_W-1:0]     DEBUG_LEN  = CNT_W'(DEBUG_MOD);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);

  state_t               state, state_nxt;
  logic [DEBUG_MOD-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 done, done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      cnt       <= cnt_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Flush wins over a simultaneous accept.
        if (i_flush) begin
          cnt_nxt = '0;
        end else if (i_frame_valid) begin
          shift_nxt = i_frame_mode ? i_frame_data : (i_frame_data & NORM_MASK);
          cnt_nxt   = i_frame_mode ? DEBUG_LEN : NORM_LEN;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (i_flush) begin
          state_nxt = IDLE;
          shift_nxt = '0;
          cnt_nxt   = '0;
        end else if (i_tx_ready && (cnt != '0)) begin
          shift_nxt = shift_reg >> 1;
          cnt_nxt   = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        shift_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign o_tx_valid    = (state == SHIFT);
  assign o_tx_data     = (state == SHIFT) & shift_reg[0];
  assign o_busy        = (state == SHIFT);
  assign o_frame_ready = (state == IDLE);
  assign o_frame_done  = done;

endmodule

`default_nettype wire

// File: tb/tb_puf_tx_serializer.sv
// Directed bench for puf_tx_serializer: frames, backpressure, back-to-back, flush and reset.
`default_nettype none

module tb_puf_tx_serializer;

  localparam int NM = 34;
  localparam int DM = 133;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_frame_valid = 1'b0;
  logic          o_frame_ready;
  logic          i_frame_mode = 1'b0;
  logic [DM-1:0] i_frame_data = '0;
  logic          i_flush = 1'b0;
  logic          i_tx_ready = 1'b0;
  logic          o_tx_data;
  logic          o_tx_valid;
  logic          o_busy;
  logic          o_frame_done;

  puf_tx_serializer #(.NORM_MOD(NM), .DEBUG_MOD(DM)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_valid (i_frame_valid),
    .o_frame_ready (o_frame_ready),
    .i_frame_mode  (i_frame_mode),
    .i_frame_data  (i_frame_data),
    .i_flush       (i_flush),
    .i_tx_ready    (i_tx_ready),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Negedge monitor: inputs are stable here and transfers happen on the next rising edge.
  logic         mon_clr = 1'b0;
  logic [255:0] rx;
  int           rx_n, done_n, stall_err, cyc, nr, nf;
  int           rises[4];
  int           falls[4];
  logic         both_hi, prev_valid, stall_prev, data_prev;

  always @(negedge clk) begin
    if (mon_clr) begin
      rx <= '0; rx_n <= 0; done_n <= 0; stall_err <= 0; cyc <= 0;
      nr <= 0; nf <= 0; both_hi <= 1'b0; prev_valid <= 1'b0;
      stall_prev <= 1'b0; data_prev <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (o_tx_valid && i_tx_ready && !i_flush && rx_n < 256) begin
        rx[rx_n] <= o_tx_data;
        rx_n     <= rx_n + 1;
      end
      if (o_frame_done) done_n <= done_n + 1;
      if (o_frame_done && o_tx_valid) both_hi <= 1'b1;
      if (o_tx_valid && !prev_valid && nr < 4) begin rises[nr] <= cyc; nr <= nr + 1; end
      if (!o_tx_valid && prev_valid && nf < 4) begin falls[nf] <= cyc; nf <= nf + 1; end
      if (o_tx_valid && stall_prev && (o_tx_data != data_prev)) stall_err <= stall_err + 1;
      prev_valid <= o_tx_valid;
      stall_prev <= o_tx_valid && !i_tx_ready;
      data_prev  <= o_tx_data;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (o_frame_done !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
  endtask

  task automatic accept(input logic mode, input logic [DM-1:0] data);
    i_frame_mode  = mode;
    i_frame_data  = data;
    i_frame_valid = 1'b1;
    step(1);
    i_frame_valid = 1'b0;
  endtask

  logic [DM-1:0] walk;
  logic [DM-1:0] dat;
  logic [3:0]    rpat;
  int            n;
  int            k;

  initial begin
    for (int i = 0; i < DM; i++) walk[i] = (i % 3 == 0);

    // Reset state, then ten quiet idle cycles.
    #2;
    check("reset_outs", {o_frame_ready, o_tx_valid, o_busy, o_frame_done, o_tx_data}, 5'b10000);
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("idle_outs", {o_frame_ready, o_tx_valid, o_busy, o_frame_done}, 4'b1000);
    end

    // Normal frame with the link always ready.
    clear_mon();
    i_tx_ready = 1'b1;
    accept(1'b0, DM'(34'h2_AAAA_5555));
    check("first_bit", {o_tx_valid, o_tx_data, o_frame_ready}, 3'b110);
    wait_done(400, n);
    check("norm_done_lat", n, 34);
    check("done_cycle", {o_frame_ready, o_tx_valid, o_busy}, 3'b100);
    step(1);
    check("norm_done_off", o_frame_done, 1'b0);
    check("norm_nbits", rx_n, 34);
    check("norm_data", rx, 256'(34'h2_AAAA_5555));
    check("norm_done_cnt", done_n, 1);
    check("norm_run", falls[0] - rises[0], 34);

    // Debug frame with the walking pattern.
    clear_mon();
    accept(1'b1, walk);
    wait_done(400, n);
    check("dbg_done_lat", n, 133);
    step(1);
    check("dbg_nbits", rx_n, 133);
    check("dbg_data", rx, 256'(walk));
    check("dbg_done_cnt", done_n, 1);
    check("dbg_run", falls[0] - rises[0], 133);

    // Normal mode: bits above the normal length must never appear.
    clear_mon();
    dat = '1;
    dat[33:0] = 34'h1_2345_6789;
    accept(1'b0, dat);
    wait_done(400, n);
    step(1);
    check("upper_nbits", rx_n, 34);
    check("upper_data", rx, 256'(34'h1_2345_6789));

    // Backpressure: ready cycles 1,0,0,1; frame inputs wiggle during SHIFT.
    clear_mon();
    rpat = 4'b1001;
    accept(1'b0, DM'(34'h1_C3A5_96E7));
    i_frame_data = '1;
    i_frame_mode = 1'b1;
    k = 0;
    while (o_frame_done !== 1'b1 && k < 600) begin
      i_tx_ready = rpat[k % 4];
      step(1);
      k++;
    end
    i_tx_ready = 1'b1;
    step(1);
    check("bp_nbits", rx_n, 34);
    check("bp_data", rx, 256'(34'h1_C3A5_96E7));
    check("bp_hold", stall_err, 0);
    check("bp_done_cnt", done_n, 1);

    // Back-to-back: normal then debug with frame_valid held throughout.
    clear_mon();
    accept(1'b0, DM'(34'h0_F00D_BEEF));
    i_frame_valid = 1'b1;
    i_frame_mode  = 1'b1;
    i_frame_data  = walk;
    wait_done(400, n);
    check("b2b_first_lat", n, 34);
    check("b2b_ready_in_done", o_frame_ready, 1'b1);
    step(1);
    i_frame_valid = 1'b0;
    check("b2b_second_valid", o_tx_valid, 1'b1);
    wait_done(400, n);
    check("b2b_second_lat", n, 133);
    step(1);
    check("b2b_nbits", rx_n, 167);
    check("b2b_data", rx, {89'd0, walk, 34'h0_F00D_BEEF});
    check("b2b_run0", falls[0] - rises[0], 34);
    check("b2b_gap", rises[1] - falls[0], 1);
    check("b2b_run1", falls[1] - rises[1], 133);
    check("b2b_done_cnt", done_n, 2);

    // Flush at bit 10 of a debug frame.
    clear_mon();
    accept(1'b1, walk);
    step(10);
    i_flush = 1'b1;
    step(1);
    i_flush = 1'b0;
    check("flush_outs", {o_tx_valid, o_frame_ready, o_busy}, 3'b010);
    step(2);
    check("flush_no_done", done_n, 0);
    check("flush_nbits", rx_n, 10);

    // Flush beats a simultaneous accept in IDLE.
    i_flush = 1'b1;
    i_frame_valid = 1'b1;
    i_frame_mode = 1'b1;
    i_frame_data = walk;
    step(1);
    i_flush = 1'b0;
    check("flush_idle_prio", o_busy, 1'b0);
    step(1);
    i_frame_valid = 1'b0;
    check("accept_after_flush", o_busy, 1'b1);

    // Asynchronous reset at bit 20, then a clean frame.
    step(20);
    rst_n = 1'b0;
    #1;
    check("async_reset", {o_frame_ready, o_tx_valid, o_busy, o_frame_done, o_tx_data}, 5'b10000);
    step(1);
    rst_n = 1'b1;
    clear_mon();
    accept(1'b0, DM'(34'h3_1234_ABCD));
    wait_done(400, n);
    step(1);
    check("post_rst_nbits", rx_n, 34);
    check("post_rst_data", rx, 256'(34'h3_1234_ABCD));
    check("post_rst_done", done_n, 1);
    check("valid_done_excl", both_hi, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/puf_tx_serializer.md
Name: puf_tx_serializer

Overview:
- Parallel-to-serial response transmitter feeding the SoC's serial host interface (o_tx_data / o_tx_valid / i_tx_ready).
- Accepts one response frame from the PUF response framer: a NORM_MOD-bit normal CRP frame or a DEBUG_MOD-bit debug frame.
- Shifts the frame out LSB-first, one bit per accepted host handshake.
- Reports frame completion back to the SoC controller.

Parameters:
- NORM_MOD, 34, bit length of a normal-mode response frame.
- DEBUG_MOD, 133, bit length of a debug-mode response frame (must be >= NORM_MOD).
- CNT_W, $clog2(DEBUG_MOD+1), width of the internal bit counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_frame_valid  input  1  framer presents a frame
- o_frame_ready  output  1  serializer can accept a frame
- i_frame_mode  input  1  0 = normal (NORM_MOD bits), 1 = debug (DEBUG_MOD bits)
- i_frame_data  input  DEBUG_MOD  frame payload, bit 0 sent first; bits >= NORM_MOD ignored in normal mode
- i_flush  input  1  synchronous abort of the current frame
- i_tx_ready  input  1  host can take a bit
- o_tx_data  output  1  serial data bit
- o_tx_valid  output  1  o_tx_data is valid
- o_busy  output  1  a frame is in flight
- o_frame_done  output  1  one-cycle pulse after the last bit is transferred

Behaviour:
- Reset (rst_n low, async): state IDLE, shift register 0, counter 0.
  - Outputs: o_tx_valid=0, o_tx_data=0, o_busy=0, o_frame_done=0, o_frame_ready=1.
- States: IDLE, SHIFT.
- IDLE:
  - o_frame_ready=1.
  - On an edge with i_frame_valid=1, the frame is accepted. Capture i_frame_data (normal mode: zero-extend the low NORM_MOD bits). Capture i_frame_mode. Load the counter with NORM_MOD or DEBUG_MOD. Go to SHIFT.
- Latency: frame accepted at edge N -> o_tx_valid=1 and o_tx_data=bit0 in the cycle after edge N.
- SHIFT:
  - o_frame_ready=0, o_busy=1, o_tx_valid=1, o_tx_data = shift_reg[0].
  - A bit transfers on an edge where o_tx_valid & i_tx_ready. The register then shifts right by 1 and the counter decrements.
  - i_tx_ready low: o_tx_data and o_tx_valid hold, the counter holds, no bit is lost or duplicated.
- Last bit (counter==1 and a transfer occurs):
  - Next state IDLE; o_tx_valid=0 the following cycle.
  - o_frame_done=1 for exactly that cycle.
  - o_frame_ready=1 in that same cycle, so back-to-back frames have exactly one idle cycle between the last and first bits.
- Unbroken stream: with i_tx_ready held high, a normal frame occupies exactly 34 consecutive valid cycles and a debug frame exactly 133.
- Mode and data are sampled only at accept. Changes to i_frame_mode or i_frame_data during SHIFT have no effect.
- i_frame_valid during SHIFT is ignored; the framer must hold it until o_frame_ready.
- i_flush:
  - In SHIFT: next edge goes to IDLE, drops o_tx_valid, clears the counter, no o_frame_done pulse. Flush takes priority over a simultaneous bit transfer.
  - In IDLE: flush has priority over accept; no frame is accepted that edge.
- Reset mid-frame: immediate return to the reset values; the partial frame is discarded.
- The counter never wraps. Counter==0 outside SHIFT.
- o_frame_done and o_tx_valid are never both high.

Test Plan:
- Reset then idle -> o_frame_ready=1, o_tx_valid=0, o_busy=0 for 10 cycles with no input activity.
- Normal frame 34'h2_AAAA_5555, i_tx_ready=1 -> o_tx_valid high 34 consecutive cycles starting the cycle after accept. Received LSB-first bits rebuild 34'h2_AAAA_5555. o_frame_done pulses once, the cycle after the 34th bit.
- Debug frame with a 133-bit walking pattern (bit k = k%3==0), i_tx_ready=1 -> exactly 133 valid bits, pattern matches, a single done pulse. Bits above 33 toggled in normal mode -> not transmitted.
- Backpressure: normal frame with i_tx_ready toggling 1,0,0,1 repeatedly -> o_tx_data stable while ready=0, 34 transfers total, payload intact.
- Back-to-back: framer presents a normal then a debug frame with i_frame_valid held -> second accept occurs in the o_frame_done cycle, exactly one invalid cycle between streams, 34 then 133 bits.
- Flush/reset: i_flush asserted at bit 10 of a debug frame -> o_tx_valid=0 next cycle, no done pulse, o_frame_ready=1. Repeat with rst_n low at bit 20 -> all outputs at reset values asynchronously; the next frame transmits correctly.
